prf_multiport_scoreboard: RTL and testbench
===========================================

// Module: prf_multiport_scoreboard
// PURPOSE
//  Parametrised physical register file with an integrated per-register ready scoreboard.
//  NUM_WR CDB write channels update data and set ready; NUM_ALLOC rename ports clear ready.
//  NUM_RD read ports return data plus a ready bit to the reservation stations, LSQ and commit/RVFI.
//  Sits between rename/dispatch and the functional units; successor to the fixed 4-write regfile.
// PARAMETERS
//  NUM_PREGS  64  physical registers; power of 2; preg 0 is hard-wired zero
//  DATA_W     32  register width
//  NUM_WR     4   CDB write channels (ALU, MUL, DIV, LS)
//  NUM_RD     16  read ports
//  NUM_ALLOC  2   rename allocation ports per cycle
// PORTS
//  clk        in   1                     clock
//  rst        in   1                     synchronous, active-high reset
//  wr_en      in   NUM_WR                CDB channel i valid
//  wr_pd      in   NUM_WR x PREG_W       destination preg per channel
//  wr_data    in   NUM_WR x DATA_W       writeback value per channel
//  alloc_en   in   NUM_ALLOC             rename allocated a new pd on port j
//  alloc_pd   in   NUM_ALLOC x PREG_W    allocated preg; its ready bit is cleared
//  flush      in   1                     mispredict recovery; all in-flight pregs squashed
//  rd_ps      in   NUM_RD x PREG_W       read address per port
//  rd_data    out  NUM_RD x DATA_W       read value per port
//  rd_rdy     out  NUM_RD                preg holds final value
//  wr_conflict out 1                     two enabled channels target the same nonzero pd
// BEHAVIOUR
//  - Reset: data[*] <= 0 and rdy[*] <= 1 on the first edge with rst high.
//    While rst is high: rd_data = 0, rd_rdy = 0, wr_conflict = 0. All other inputs are ignored.
//  - Preg 0: never written, never cleared. A read of preg 0 returns data 0 with rdy 1.
//  - Write: wr_en[i] && wr_pd[i] != 0 -> data[wr_pd] <= wr_data and rdy[wr_pd] <= 1 at the next edge.
//  - Alloc: alloc_en[j] && alloc_pd[j] != 0 -> rdy[alloc_pd] <= 0 at the next edge.
//  - Priority on the ready bit at one edge: flush > alloc > write. Data writes are never suppressed.
//  - Same pd on two write channels in one cycle is illegal:
//    wr_conflict = 1 combinationally, the highest channel index wins, and an assertion fires.
//  - Flush: rdy[*] <= 1 for all pregs and same-cycle allocs are dropped.
//    Squashed pregs return to the free list, and every mapped preg is architecturally complete.
//  - Reads are combinational from the array. Latency 0 from rd_ps to rd_data/rd_rdy.
//  - A write issued in cycle N is visible to a plain array read in cycle N+1.
//  - An alloc in cycle N gives rdy = 0 on reads from cycle N+1.
// CONFIGURATION
//  - PRF_BYPASS_EN defined: same-cycle write-to-read bypass.
//    If rd_ps[k] != 0 matches an enabled wr_pd[i], then rd_data[k] = wr_data[i] and rd_rdy[k] = 1 in cycle N.
//    When several channels match, the highest index wins.
//    The bypass is not applied while rst is high.
//  - PRF_BYPASS_EN undefined: no bypass. Reads see the array only, and newly written data appears at N+1.
// STRUCTURE
//  - ooo_pkg: PREG_W = $clog2(NUM_PREGS); typedef logic [PREG_W-1:0] preg_t; typedef logic [DATA_W-1:0] word_t.
//  - Sub-module prf_bypass_mux (one instance per read port).
//    Inputs: array value, wr_en/wr_pd/wr_data. Outputs: data and hit.
//    It is instantiated only under PRF_BYPASS_EN.
//  - Write decode, alloc/flush ready update and conflict detection stay in this module.
// TESTING
//  1 Reset, then read ports 0..15 on pregs 0..15 -> every rd_data = 0 and every rd_rdy = 1.
//  2 alloc_pd = 5 in cycle 1; wr_pd[1] = 5, wr_data = 0xDEADBEEF in cycle 3.
//    -> rd_rdy = 0 in cycles 2-3.
//    -> cycle 4: data 0xDEADBEEF, rdy 1.
//    -> with PRF_BYPASS_EN: data 0xDEADBEEF, rdy 1 already in cycle 3.
//  3 Write of 0x1234 to preg 0 -> a read of preg 0 still returns 0/rdy 1.
//    An alloc of preg 0 leaves rdy = 1.
//  4 Channels 0 and 3 both write pd 9 (0xA / 0xB) -> wr_conflict = 1; next-cycle read of preg 9 = 0xB.
//  5 Alloc pd 7 and pd 8; two cycles later flush together with an alloc of pd 10.
//    -> next cycle rdy[7], rdy[8] and rdy[10] all = 1; data unchanged.
//  6 Alloc pd 12 and write pd 12 = 0x55 in the same cycle -> next cycle data 0x55, rdy 0.
//    Assert rst mid-stream -> next cycle all pregs read 0 with rdy 1.

Source files
------------

// File: rtl/ooo_pkg.sv
// ---------------------------------------------------------------------------
// ooo_pkg
// Shared definitions for the out-of-order core's physical register file.
//   PRF_*     : default sizing of the physical register file
//   PREG_W    : bits needed to name one physical register
//   preg_t    : physical register index type
//   word_t    : architectural data word type
// ---------------------------------------------------------------------------
package ooo_pkg;

    localparam int PRF_NUM_PREGS = 64;
    localparam int PRF_DATA_W    = 32;
    localparam int PRF_NUM_WR    = 4;
    localparam int PRF_NUM_RD    = 16;
    localparam int PRF_NUM_ALLOC = 2;

    localparam int PREG_W = $clog2(PRF_NUM_PREGS);

    typedef logic [PREG_W-1:0]     preg_t;
    typedef logic [PRF_DATA_W-1:0] word_t;

endpackage

// File: rtl/prf_bypass_mux.sv
// ---------------------------------------------------------------------------
// prf_bypass_mux
// One read port's same-cycle write-to-read forwarding. If the read address
// is nonzero and matches an enabled CDB channel, the channel's data replaces
// the array value; with several matches the highest channel index wins,
// mirroring which channel actually lands in the array at the next edge.
// Ports:
//   arr_data_i : value read from the register array
//   rd_ps_i    : read address of this port
//   wr_en_i    : CDB channel valids
//   wr_pd_i    : CDB destination pregs
//   wr_data_i  : CDB writeback values
//   data_o     : forwarded or array value
//   hit_o      : a CDB channel supplied data_o
// ---------------------------------------------------------------------------
module prf_bypass_mux
    import ooo_pkg::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int DATA_W    = PRF_DATA_W,
    parameter int NUM_WR    = PRF_NUM_WR
) (
    input  logic [DATA_W-1:0]                          arr_data_i,
    input  logic [$clog2(NUM_PREGS)-1:0]               rd_ps_i,
    input  logic [NUM_WR-1:0]                          wr_en_i,
    input  logic [NUM_WR-1:0][$clog2(NUM_PREGS)-1:0]   wr_pd_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]              wr_data_i,
    output logic [DATA_W-1:0]                          data_o,
    output logic                                       hit_o
);

    // Ascending scan so a later (higher) matching channel overrides earlier ones.
    always_comb begin
        data_o = arr_data_i;
        hit_o  = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en_i[i] && (wr_pd_i[i] == rd_ps_i) && (rd_ps_i != '0)) begin
                data_o = wr_data_i[i];
                hit_o  = 1'b1;
            end else begin
                data_o = data_o;
                hit_o  = hit_o;
            end
        end
    end

endmodule

// File: rtl/prf_multiport_scoreboard_chk.sv
// ---------------------------------------------------------------------------
// prf_multiport_scoreboard_chk
// Assertion companion for the register file: flags two CDB channels writing
// the same nonzero preg in one cycle. The condition is reported as a warning
// so recovery-path bring-up can continue past it.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   wr_conflict_i : conflict indication from the register file
// ---------------------------------------------------------------------------
module prf_multiport_scoreboard_chk (
    input logic clk,
    input logic rst,
    input logic wr_conflict_i
);

    // Sample the conflict flag at each edge outside reset.
    always @(posedge clk) begin
        if (!rst) begin
            a_no_wr_conflict: assert (!wr_conflict_i)
                else $warning("prf: two CDB channels target the same preg");
        end
    end

endmodule

// File: rtl/prf_multiport_scoreboard.sv
// ---------------------------------------------------------------------------
// prf_multiport_scoreboard
// Physical register file with an integrated per-register ready scoreboard.
// CDB writes store data and set ready; rename allocations clear ready; a
// flush sets every ready bit (squashed pregs go back to the free list).
// Ready priority at one edge: flush > alloc > write. Data writes always land.
// Preg 0 is hard-wired zero and always ready.
// Build option: define PRF_BYPASS_EN for same-cycle write-to-read forwarding.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   wr_en/pd/data : NUM_WR CDB writeback channels
//   alloc_en/pd : NUM_ALLOC rename allocation ports
//   flush       : mispredict recovery
//   rd_ps       : NUM_RD read addresses
//   rd_data/rdy : combinational read data and ready bit
//   wr_conflict : two enabled channels target the same nonzero preg
// ---------------------------------------------------------------------------
module prf_multiport_scoreboard
    import ooo_pkg::*;
#(
    parameter int NUM_PREGS = PRF_NUM_PREGS,
    parameter int DATA_W    = PRF_DATA_W,
    parameter int NUM_WR    = PRF_NUM_WR,
    parameter int NUM_RD    = PRF_NUM_RD,
    parameter int NUM_ALLOC = PRF_NUM_ALLOC
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_WR-1:0]                           wr_en,
    input  logic [NUM_WR-1:0][$clog2(NUM_PREGS)-1:0]    wr_pd,
    input  logic [NUM_WR-1:0][DATA_W-1:0]               wr_data,
    input  logic [NUM_ALLOC-1:0]                        alloc_en,
    input  logic [NUM_ALLOC-1:0][$clog2(NUM_PREGS)-1:0] alloc_pd,
    input  logic                                        flush,
    input  logic [NUM_RD-1:0][$clog2(NUM_PREGS)-1:0]    rd_ps,
    output logic [NUM_RD-1:0][DATA_W-1:0]               rd_data,
    output logic [NUM_RD-1:0]                           rd_rdy,
    output logic                                        wr_conflict
);

    logic [NUM_PREGS-1:0][DATA_W-1:0] data_q, data_d;
    logic [NUM_PREGS-1:0]             rdy_q,  rdy_d;
    logic                             conflict_s;

    // Next-state of data array and ready scoreboard.
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        // Ascending order: the highest-index channel wins a same-pd collision.
        for (int i = 0; i < NUM_WR; i++) begin
            if (wr_en[i] && (wr_pd[i] != '0)) begin
                data_d[wr_pd[i]] = wr_data[i];
                rdy_d[wr_pd[i]]  = 1'b1;
            end else begin
                data_d = data_d;
            end
        end
        // Allocations override a same-cycle write's ready; flush overrides both
        // and drops the allocations entirely.
        if (flush) begin
            rdy_d = '1;
        end else begin
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (alloc_en[j] && (alloc_pd[j] != '0)) begin
                    rdy_d[alloc_pd[j]] = 1'b0;
                end else begin
                    rdy_d = rdy_d;
                end
            end
        end
        data_d[0] = '0;
        rdy_d[0]  = 1'b1;
    end

    // Array and scoreboard state.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            rdy_q  <= '1;
        end else begin
            data_q <= data_d;
            rdy_q  <= rdy_d;
        end
    end

    // Pairwise same-destination detection across enabled channels.
    always_comb begin
        conflict_s = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (wr_en[i] && wr_en[j] && (wr_pd[i] == wr_pd[j]) && (wr_pd[i] != '0)) begin
                    conflict_s = 1'b1;
                end else begin
                    conflict_s = conflict_s;
                end
            end
        end
    end

    assign wr_conflict = rst ? 1'b0 : conflict_s;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [DATA_W-1:0] arr_s;
        logic [DATA_W-1:0] val_s;
        logic              hit_s;

        assign arr_s = data_q[rd_ps[k]];

`ifdef PRF_BYPASS_EN
        prf_bypass_mux #(
            .NUM_PREGS (NUM_PREGS),
            .DATA_W    (DATA_W),
            .NUM_WR    (NUM_WR)
        ) u_bypass (
            .arr_data_i (arr_s),
            .rd_ps_i    (rd_ps[k]),
            .wr_en_i    (wr_en),
            .wr_pd_i    (wr_pd),
            .wr_data_i  (wr_data),
            .data_o     (val_s),
            .hit_o      (hit_s)
        );
`else
        assign val_s = arr_s;
        assign hit_s = 1'b0;
`endif

        // Reset masks the read ports so consumers never see ready during reset.
        assign rd_data[k] = rst ? '0   : val_s;
        assign rd_rdy[k]  = rst ? 1'b0 : (hit_s | rdy_q[rd_ps[k]]);
    end

    prf_multiport_scoreboard_chk u_chk (
        .clk           (clk),
        .rst           (rst),
        .wr_conflict_i (wr_conflict)
    );

endmodule

// File: tb/tb_prf_multiport_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_prf_multiport_scoreboard
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural register-file model held in plain arrays.
// ---------------------------------------------------------------------------
module tb_prf_multiport_scoreboard;

    localparam int NP = 64;
    localparam int DW = 32;
    localparam int NW = 4;
    localparam int NR = 16;
    localparam int NA = 2;
    localparam int PW = 6;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NW-1:0]           wr_en;
    logic [NW-1:0][PW-1:0]   wr_pd;
    logic [NW-1:0][DW-1:0]   wr_data;
    logic [NA-1:0]           alloc_en;
    logic [NA-1:0][PW-1:0]   alloc_pd;
    logic                    flush;
    logic [NR-1:0][PW-1:0]   rd_ps;
    logic [NR-1:0][DW-1:0]   rd_data;
    logic [NR-1:0]           rd_rdy;
    logic                    wr_conflict;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] m_data [NP];
    bit            m_rdy  [NP];

    prf_multiport_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_pd       (wr_pd),
        .wr_data     (wr_data),
        .alloc_en    (alloc_en),
        .alloc_pd    (alloc_pd),
        .flush       (flush),
        .rd_ps       (rd_ps),
        .rd_data     (rd_data),
        .rd_rdy      (rd_rdy),
        .wr_conflict (wr_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_pd    = '0;
        wr_data  = '0;
        alloc_en = '0;
        alloc_pd = '0;
        flush    = 1'b0;
    endtask

    // Model state after the coming edge, from the rules of the register file.
    task automatic model_step();
        bit written, allocated;
        if (rst) begin
            for (int p = 0; p < NP; p++) begin
                m_data[p] = '0;
                m_rdy[p]  = 1'b1;
            end
            return;
        end
        for (int i = 0; i < NW; i++)
            if (wr_en[i] && wr_pd[i] != 0) m_data[wr_pd[i]] = wr_data[i];
        for (int p = 1; p < NP; p++) begin
            written = 1'b0;
            allocated = 1'b0;
            for (int i = 0; i < NW; i++) if (wr_en[i] && wr_pd[i] == p) written = 1'b1;
            for (int j = 0; j < NA; j++) if (alloc_en[j] && alloc_pd[j] == p) allocated = 1'b1;
            if (flush)          m_rdy[p] = 1'b1;
            else if (allocated) m_rdy[p] = 1'b0;
            else if (written)   m_rdy[p] = 1'b1;
        end
    endtask

    // Compare every read port and the conflict flag with the model.
    task automatic sample();
        logic [DW-1:0] ed;
        bit            er, ec;
        #2;
        for (int k = 0; k < NR; k++) begin
            if (rst) begin
                ed = '0;
                er = 1'b0;
            end else begin
                ed = m_data[rd_ps[k]];
                er = m_rdy[rd_ps[k]];
`ifdef PRF_BYPASS_EN
                for (int i = NW - 1; i >= 0; i--) begin
                    if (wr_en[i] && rd_ps[k] != 0 && wr_pd[i] == rd_ps[k]) begin
                        ed = wr_data[i];
                        er = 1'b1;
                        break;
                    end
                end
`endif
            end
            chk($sformatf("rd_data[%0d] ps=%0d", k, rd_ps[k]), rd_data[k], ed);
            chk($sformatf("rd_rdy[%0d] ps=%0d", k, rd_ps[k]), 32'(rd_rdy[k]), 32'(er));
        end
        ec = 1'b0;
        for (int i = 0; i < NW; i++)
            for (int j = i + 1; j < NW; j++)
                if (!rst && wr_en[i] && wr_en[j] && wr_pd[i] == wr_pd[j] && wr_pd[i] != 0) ec = 1'b1;
        chk("wr_conflict", 32'(wr_conflict), 32'(ec));
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int k = 0; k < NR; k++) rd_ps[k] = PW'(k);

        // Reset: outputs masked while rst is high.
        sample();
        chk("rst rdy masked", 32'(rd_rdy), 32'h0);
        advance();
        sample();
        advance();
        rst = 1'b0;

        // Test 1: pregs 0..15 read zero and ready after reset.
        sample();
        for (int k = 0; k < NR; k++) chk($sformatf("t1 data%0d", k), rd_data[k], 32'h0);
        chk("t1 rdy", 32'(rd_rdy), 32'h0000_FFFF);
        advance();

        // Test 2: alloc 5, then write 5 two cycles later.
        rd_ps[0] = PW'(5);
        alloc_en[0] = 1'b1;
        alloc_pd[0] = PW'(5);
        sample();
        advance();
        idle();
        sample();
        chk("t2 rdy c2", 32'(rd_rdy[0]), 32'h0);
        advance();
        wr_en[1]   = 1'b1;
        wr_pd[1]   = PW'(5);
        wr_data[1] = 32'hDEADBEEF;
        sample();
`ifdef PRF_BYPASS_EN
        chk("t2 data c3 bypass", rd_data[0], 32'hDEADBEEF);
        chk("t2 rdy c3 bypass", 32'(rd_rdy[0]), 32'h1);
`else
        chk("t2 rdy c3", 32'(rd_rdy[0]), 32'h0);
`endif
        advance();
        idle();
        sample();
        chk("t2 data c4", rd_data[0], 32'hDEADBEEF);
        chk("t2 rdy c4", 32'(rd_rdy[0]), 32'h1);
        advance();

        // Test 3: preg 0 ignores writes and allocations.
        rd_ps[0]    = PW'(0);
        wr_en[0]    = 1'b1;
        wr_pd[0]    = PW'(0);
        wr_data[0]  = 32'h1234;
        alloc_en[1] = 1'b1;
        alloc_pd[1] = PW'(0);
        sample();
        chk("t3 data same", rd_data[0], 32'h0);
        advance();
        idle();
        sample();
        chk("t3 data next", rd_data[0], 32'h0);
        chk("t3 rdy next", 32'(rd_rdy[0]), 32'h1);
        advance();

        // Test 4: channels 0 and 3 both write preg 9; channel 3 wins.
        rd_ps[0]   = PW'(9);
        wr_en      = 4'b1001;
        wr_pd[0]   = PW'(9);
        wr_pd[3]   = PW'(9);
        wr_data[0] = 32'hA;
        wr_data[3] = 32'hB;
        sample();
        chk("t4 conflict", 32'(wr_conflict), 32'h1);
        advance();
        idle();
        sample();
        chk("t4 data", rd_data[0], 32'hB);
        chk("t4 conflict clear", 32'(wr_conflict), 32'h0);
        advance();

        // Test 5: alloc 7/8, flush two cycles later with a dropped alloc of 10.
        rd_ps[0] = PW'(7);
        rd_ps[1] = PW'(8);
        rd_ps[2] = PW'(10);
        alloc_en = 2'b11;
        alloc_pd[0] = PW'(7);
        alloc_pd[1] = PW'(8);
        sample();
        advance();
        idle();
        sample();
        chk("t5 rdy7 low", 32'(rd_rdy[0]), 32'h0);
        advance();
        flush       = 1'b1;
        alloc_en[0] = 1'b1;
        alloc_pd[0] = PW'(10);
        sample();
        advance();
        idle();
        sample();
        chk("t5 rdy 7/8/10", 32'(rd_rdy[2:0]), 32'h7);
        chk("t5 data7", rd_data[0], 32'h0);
        chk("t5 data10", rd_data[2], 32'h0);
        advance();

        // Test 6: alloc and write the same preg; alloc wins the ready bit.
        rd_ps[0]    = PW'(12);
        alloc_en[0] = 1'b1;
        alloc_pd[0] = PW'(12);
        wr_en[2]    = 1'b1;
        wr_pd[2]    = PW'(12);
        wr_data[2]  = 32'h55;
        sample();
        advance();
        idle();
        sample();
        chk("t6 data", rd_data[0], 32'h55);
        chk("t6 rdy", 32'(rd_rdy[0]), 32'h0);
        advance();

        // Mid-stream reset clears everything written so far.
        rst = 1'b1;
        wr_en[0]   = 1'b1;
        wr_pd[0]   = PW'(3);
        wr_data[0] = 32'h77;
        sample();
        chk("t6 rst data", rd_data[0], 32'h0);
        advance();
        idle();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) rd_ps[k] = PW'(k);
        sample();
        for (int k = 0; k < NR; k++) chk($sformatf("t6 post-rst data%0d", k), rd_data[k], 32'h0);
        chk("t6 post-rst rdy", 32'(rd_rdy), 32'h0000_FFFF);
        advance();

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < NW; i++) begin
                wr_en[i]   = 1'($urandom_range(0, 1));
                wr_pd[i]   = PW'(i * 16 + $urandom_range(0, 15));
                wr_data[i] = $urandom;
            end
            if ($urandom_range(0, 31) == 0) wr_pd[3] = wr_pd[0];
            for (int j = 0; j < NA; j++) begin
                alloc_en[j] = 1'($urandom_range(0, 1));
                alloc_pd[j] = PW'($urandom_range(0, NP - 1));
            end
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 1) == 1) rd_ps[k] = wr_pd[$urandom_range(0, NW - 1)];
                else                           rd_ps[k] = PW'($urandom_range(0, NP - 1));
            end
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
